// File: rtl/i2s_tone_tx.sv
// I2S transmitter: buffers one stereo pair and serializes it MSB-first with
// self-generated SCK and WS, one-bit data delay after each WS edge.
module i2s_tone_tx #(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SAMPLE_WIDTH-1:0] in_left,
    input  logic [SAMPLE_WIDTH-1:0] in_right,
    output logic                    sck,
    output logic                    ws,
    output logic                    sd,
    output logic                    frame_start,
    output logic                    underrun
);
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int POS_W      = $clog2(FRAME_BITS);
    localparam int PAD        = SLOT_WIDTH - SAMPLE_WIDTH;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_BITS - 1);
    localparam logic [POS_W-1:0] POS_RIGHT = POS_W'(SLOT_WIDTH);

    logic [DIV_W-1:0]        div_cnt;
    logic [POS_W-1:0]        pos;
    logic [POS_W-1:0]        pos_next;
    logic [FRAME_BITS-1:0]   shreg;
    logic                    buf_full;
    logic [SAMPLE_WIDTH-1:0] buf_left;
    logic [SAMPLE_WIDTH-1:0] buf_right;
    logic [SLOT_WIDTH-1:0]   left_slot;
    logic [SLOT_WIDTH-1:0]   right_slot;
    logic                    div_wrap;
    logic                    fall;
    logic                    load;
    logic                    accept;

    assign in_ready = !buf_full;
    assign accept   = in_valid && in_ready;
    assign div_wrap = (div_cnt == DIV_LAST);
    assign fall     = div_wrap && sck;
    assign load     = fall && (pos == POS_LAST);
    assign pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;

    // Samples sit MSB-aligned in their slot, trailing bits padded with zeros.
    assign left_slot  = SLOT_WIDTH'(buf_left) << PAD;
    assign right_slot = SLOT_WIDTH'(buf_right) << PAD;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            sck         <= 1'b0;
            ws          <= 1'b1;
            sd          <= 1'b0;
            pos         <= POS_LAST;
            shreg       <= '0;
            buf_full    <= 1'b0;
            buf_left    <= '0;
            buf_right   <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load;
            underrun    <= load && !buf_full;

            if (div_wrap) begin
                div_cnt <= '0;
                sck     <= ~sck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // sd always takes the register MSB, so the load fall still emits
            // the previous frame's final right-slot bit: the one-bit delay.
            if (fall) begin
                pos <= pos_next;
                ws  <= (pos_next >= POS_RIGHT);
                sd  <= shreg[FRAME_BITS-1];
                if (load) begin
                    shreg <= buf_full ? {left_slot, right_slot} : '0;
                end else begin
                    shreg <= shreg << 1;
                end
            end

            if (load && buf_full) begin
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_full  <= 1'b1;
                buf_left  <= in_left;
                buf_right <= in_right;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tone_tx.sv
// Scoreboard bench for i2s_tone_tx: a default instance and a narrow-sample,
// CLK_DIV=1 instance, both checked against a frame-level reference model.
module tb_i2s_tone_tx;
    localparam int S = 16;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        vld [2];
    logic [15:0] lft [2];
    logic [15:0] rgt [2];
    logic [1:0]  rdy, sck_o, ws_o, sd_o, fs_o, ur_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tmo [2];
    bit          finish_req = 1'b0;

    // Reference model state, one entry per instance.
    int          n_edge [2];
    int          pos [2];
    bit          full [2];
    logic [31:0] pairq [2][$];
    bit          bitq [2][$];
    bit          last_sd [2];
    bit          rst_s [2] = '{1'b1, 1'b1};
    bit          xfer_s [2];
    logic [31:0] pair_s [2];

    always #5 clk = ~clk;

    i2s_tone_tx #(.CLK_DIV(4), .SAMPLE_WIDTH(16), .SLOT_WIDTH(16)) dut0 (
        .clk(clk), .reset(rst[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_left(lft[0]), .in_right(rgt[0]), .sck(sck_o[0]), .ws(ws_o[0]),
        .sd(sd_o[0]), .frame_start(fs_o[0]), .underrun(ur_o[0])
    );

    i2s_tone_tx #(.CLK_DIV(1), .SAMPLE_WIDTH(12), .SLOT_WIDTH(16)) dut1 (
        .clk(clk), .reset(rst[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_left(lft[1][11:0]), .in_right(rgt[1][11:0]), .sck(sck_o[1]), .ws(ws_o[1]),
        .sd(sd_o[1]), .frame_start(fs_o[1]), .underrun(ur_o[1])
    );

    task automatic check_output(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d: got %b expected %b at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair; returns once the transfer edge has passed.
    task automatic apply_stimulus(input int i, input logic [15:0] l, input logic [15:0] r, input bit hold);
        bit ok;
        ok     = 1'b0;
        lft[i] = l;
        rgt[i] = r;
        vld[i] = 1'b1;
        for (int t = 0; t < 2000 && !ok; t++) begin
            if (rdy[i]) ok = 1'b1;
            tick();
        end
        if (!ok) tmo[i]++;
        if (!hold) vld[i] = 1'b0;
    endtask

    task automatic wait_frame_start(input int i);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000 && !ok; t++) begin
            tick();
            if (fs_o[i]) ok = 1'b1;
        end
        if (!ok) tmo[i]++;
    endtask

    task automatic idle(input int cycles);
        for (int t = 0; t < cycles; t++) tick();
    endtask

    // Monitor: replays each clk edge through the model and compares outputs.
    always @(negedge clk) begin
        int          cd, w;
        bit          fall, load, ur_exp;
        logic [31:0] pr;
        logic [15:0] smp;
        bit          fb;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            cd     = (i == 0) ? 4 : 1;
            w      = (i == 0) ? 16 : 12;
            load   = 1'b0;
            ur_exp = 1'b0;
            if (rst_s[i]) begin
                n_edge[i]  = 0;
                pos[i]     = 2 * S - 1;
                full[i]    = 1'b0;
                last_sd[i] = 1'b0;
                pairq[i].delete();
                bitq[i].delete();
                bitq[i].push_back(1'b0);
                check_output("reset_sck", i, sck_o[i], 1'b0);
                check_output("reset_ws", i, ws_o[i], 1'b1);
                check_output("reset_sd", i, sd_o[i], 1'b0);
                check_output("reset_frame_start", i, fs_o[i], 1'b0);
                check_output("reset_underrun", i, ur_o[i], 1'b0);
                check_output("reset_in_ready", i, rdy[i], 1'b1);
            end else begin
                n_edge[i]++;
                fall = ((n_edge[i] / cd) % 2 == 0) && (((n_edge[i] - 1) / cd) % 2 == 1);
                if (fall) begin
                    pos[i] = (pos[i] + 1) % (2 * S);
                    load   = (pos[i] == 0);
                    if (bitq[i].size() > 0) last_sd[i] = bitq[i].pop_front();
                end
                if (load) begin
                    if (full[i]) begin
                        pr      = pairq[i].pop_front();
                        full[i] = 1'b0;
                    end else begin
                        pr     = '0;
                        ur_exp = 1'b1;
                    end
                    for (int k = 0; k < 2 * S; k++) begin
                        smp = (k < S) ? pr[31:16] : pr[15:0];
                        fb  = ((k % S) < w) ? smp[w - 1 - (k % S)] : 1'b0;
                        bitq[i].push_back(fb);
                    end
                end
                if (xfer_s[i]) begin
                    pairq[i].push_back(pair_s[i]);
                    full[i] = 1'b1;
                end
                check_output("sck", i, sck_o[i], ((n_edge[i] / cd) % 2) == 1);
                check_output("ws", i, ws_o[i], pos[i] >= S);
                check_output("sd", i, sd_o[i], last_sd[i]);
                check_output("frame_start", i, fs_o[i], load);
                check_output("underrun", i, ur_o[i], load && ur_exp);
                check_output("in_ready", i, rdy[i], !full[i]);
            end
            rst_s[i]  = rst[i];
            xfer_s[i] = vld[i] && !full[i];
            pair_s[i] = {lft[i], rgt[i]};
        end
        if (finish_req || cyc > 50000) begin
            check_output("no_timeout_inst0", 0, tmo[0] == 0, 1'b1);
            check_output("no_timeout_inst1", 1, tmo[1] == 0, 1'b1);
            check_output("within_cycle_budget", 0, cyc <= 50000, 1'b1);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        logic [15:0] fixed_l [3];
        logic [15:0] fixed_r [3];
        fixed_l = '{16'h1234, 16'h8001, 16'h00FF};
        fixed_r = '{16'hFEDC, 16'h7FFE, 16'hFF00};
        tmo     = '{0, 0};
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            vld[i] = 1'b0;
            lft[i] = '0;
            rgt[i] = '0;
        end
        $display("[TB] reset, then an idle underrun frame");
        idle(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        idle(300);

        $display("[TB] narrow-sample instance at CLK_DIV=1");
        rst[1] = 1'b1;
        idle(2);
        rst[1] = 1'b0;
        apply_stimulus(1, 16'h0FFF, 16'(($urandom & 32'hFFF)), 1'b0);
        for (int p = 0; p < 8; p++)
            apply_stimulus(1, 16'($urandom & 32'hFFF), 16'($urandom & 32'hFFF), p != 7);
        idle(200);

        $display("[TB] single pair right after reset, then starve");
        rst[0] = 1'b1;
        idle(2);
        rst[0] = 1'b0;
        apply_stimulus(0, 16'hA5C3, 16'h0F01, 1'b0);
        idle(600);

        $display("[TB] streaming fixed and random pairs");
        for (int p = 0; p < 3; p++) apply_stimulus(0, fixed_l[p], fixed_r[p], 1'b1);
        for (int p = 0; p < 5; p++) begin
            if ($urandom_range(0, 2) == 0) begin
                vld[0] = 1'b0;
                idle($urandom_range(1, 300));
            end
            apply_stimulus(0, 16'($urandom), 16'($urandom), p != 4);
        end
        idle(600);

        $display("[TB] reset mid left slot with a pair buffered");
        apply_stimulus(0, 16'($urandom), 16'($urandom), 1'b0);
        wait_frame_start(0);
        apply_stimulus(0, 16'($urandom), 16'($urandom), 1'b0);
        idle(7 * 8 - 2);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        idle(300);

        finish_req = 1'b1;
    end
endmodule
